// File: rtl/cpu_core_pkg.sv
// cpu_core_pkg: shared opcode constants, FSM state encodings and flag bit
// indices for the cpu_core_p accumulator core.
package cpu_core_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ST_F0   = 3'd0,
    ST_F1   = 3'd1,
    ST_EX   = 3'd2,
    ST_MEM  = 3'd3,
    ST_HALT = 3'd4
  } state_e;

  // Bit positions inside o_flags = {C,Z}
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

endpackage

// File: rtl/alu_cz.sv
// alu_cz: combinational add/subtract with carry and zero outputs.
//   a_i, b_i  : operands
//   sub_i     : 1 = a_i - b_i computed as a_i + ~b_i + 1
//   sum_o     : DATA_W-bit modular result
//   c_o       : carry-out (for subtract, 1 means no borrow)
//   z_o       : result is zero
module alu_cz #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              sub_i,
  output logic [DATA_W-1:0] sum_o,
  output logic              c_o,
  output logic              z_o
);

  logic [DATA_W-1:0] b_eff;

  assign b_eff = sub_i ? ~b_i : b_i;
  assign {c_o, sum_o} = {1'b0, a_i} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub_i};
  assign z_o = (sum_o == '0);

endmodule

// File: rtl/cpu_core_p.sv
// cpu_core_p: minimal accumulator CPU with synchronous-read memory port.
// Ports:
//   i_clk, i_rst (async, active high), i_en (run enable, freezes all state)
//   o_mem_addr / i_mem_rdata (read data valid one cycle after address)
//   o_mem_wr / o_mem_wdata   (store strobe and data)
//   o_out / o_out_valid      (output register and its one-cycle update pulse)
//   o_flags = {C,Z}, o_halted
// Build option: define CPU_CORE_P_CJMP_EN to build the C/Z flag registers and
// the JC/JZ conditional jumps; otherwise o_flags is 0 and JC/JZ act as NOP.
//
// state | meaning
// F0    | drive PC as fetch address
// F1    | capture instruction word, increment PC
// EX    | decode/execute; LDA/ADD/SUB drive operand address
// MEM   | LDA/ADD/SUB consume read data into A
// HALT  | frozen until reset
module cpu_core_p
  import cpu_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_mem_wr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [DATA_W-1:0] o_out,
  output logic              o_out_valid,
  output logic [1:0]        o_flags,
  output logic              o_halted
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] out_q, out_d;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] alu_sum;
  logic              alu_c, alu_z;

  assign opcode  = ir_q[DATA_W-1 -: 4];
  assign operand = ir_q[ADDR_W-1:0];
  assign imm     = {4'b0, ir_q[DATA_W-5:0]};

  alu_cz #(.DATA_W(DATA_W)) u_alu (
    .a_i  (acc_q),
    .b_i  (i_mem_rdata),
    .sub_i(opcode == OP_SUB),
    .sum_o(alu_sum),
    .c_o  (alu_c),
    .z_o  (alu_z)
  );

`ifdef CPU_CORE_P_CJMP_EN
  logic [1:0] flags_q, flags_d;
  assign o_flags = flags_q;
`else
  logic unused_cz;
  assign unused_cz = alu_c | alu_z;
  assign o_flags   = 2'b00;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_F0;
      pc_q    <= '0;
      ir_q    <= '0;
      acc_q   <= '0;
      out_q   <= '0;
`ifdef CPU_CORE_P_CJMP_EN
      flags_q <= '0;
`endif
    end else if (i_en) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
`ifdef CPU_CORE_P_CJMP_EN
      flags_q <= flags_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    acc_d      = acc_q;
    out_d      = out_q;
`ifdef CPU_CORE_P_CJMP_EN
    flags_d    = flags_q;
`endif
    o_mem_addr = pc_q;
    case (state_q)
      ST_F0: state_d = ST_F1;
      ST_F1: begin
        ir_d    = i_mem_rdata;
        pc_d    = pc_q + 1'b1;
        state_d = ST_EX;
      end
      ST_EX: begin
        state_d = ST_F0;
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB: begin
            o_mem_addr = operand;
            state_d    = ST_MEM;
          end
          OP_STA: o_mem_addr = operand;
          OP_LDI: acc_d = imm;
          OP_JMP: pc_d = operand;
`ifdef CPU_CORE_P_CJMP_EN
          OP_JC:  if (flags_q[FLAG_C]) pc_d = operand;
          OP_JZ:  if (flags_q[FLAG_Z]) pc_d = operand;
`else
          OP_JC, OP_JZ: ;
`endif
          OP_OUT: out_d = acc_q;
          OP_HLT: state_d = ST_HALT;
          OP_NOP: ;
          default: ;
        endcase
      end
      ST_MEM: begin
        o_mem_addr = operand;
        state_d    = ST_F0;
        if (opcode == OP_LDA) begin
          acc_d = i_mem_rdata;
        end else begin
          acc_d = alu_sum;
`ifdef CPU_CORE_P_CJMP_EN
          flags_d[FLAG_C] = alu_c;
          flags_d[FLAG_Z] = alu_z;
`endif
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_F0;
    endcase
  end

  // IR only changes in F1, so in F0 it still names the instruction that just
  // retired; an OUT seen there means o_out was written on the previous edge.
  assign o_out_valid = i_en && (state_q == ST_F0) && (opcode == OP_OUT);
  assign o_mem_wr    = i_en && (state_q == ST_EX) && (opcode == OP_STA);
  assign o_mem_wdata = acc_q;
  assign o_out       = out_q;
  assign o_halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_cpu_core_p.sv
module tb_cpu_core_p;

`ifdef CPU_CORE_P_CJMP_EN
  localparam bit CJ = 1'b1;
`else
  localparam bit CJ = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [3:0] mem_addr;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_wr;
  logic [7:0] mem_wdata;
  logic [7:0] out_val;
  logic       out_valid;
  logic [1:0] flags;
  logic       halted;

  logic [7:0] mem [16];

  int n_cmp   = 0;
  int n_err   = 0;
  int n_valid = 0;
  int n_wr    = 0;

  always #5 clk = ~clk;

  always @(posedge clk) mem_rdata <= mem[mem_addr];

  cpu_core_p #(.DATA_W(8), .ADDR_W(4)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .o_mem_addr (mem_addr),
    .i_mem_rdata(mem_rdata),
    .o_mem_wr   (mem_wr),
    .o_mem_wdata(mem_wdata),
    .o_out      (out_val),
    .o_out_valid(out_valid),
    .o_flags    (flags),
    .o_halted   (halted)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) n_valid++;
      if (mem_wr) n_wr++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b1;
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    n_valid = 0;
    n_wr    = 0;
  endtask

  initial begin
    // Program: LDA 14; ADD 15; OUT; HLT
    clear_mem();
    mem[0] = 8'h1E; mem[1] = 8'h2F; mem[2] = 8'hE0; mem[3] = 8'hF0;
    mem[14] = 8'd28; mem[15] = 8'd14;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_addr",   {28'd0, mem_addr}, 32'd0);
    check_val("rst_wr",     {31'd0, mem_wr}, 32'd0);
    check_val("rst_valid",  {31'd0, out_valid}, 32'd0);
    check_val("rst_out",    {24'd0, out_val}, 32'd0);
    check_val("rst_flags",  {30'd0, flags}, 32'd0);
    check_val("rst_halted", {31'd0, halted}, 32'd0);
    do_reset();
    run(11);
    check_val("add_valid", {31'd0, out_valid}, 32'd1);
    check_val("add_out",   {24'd0, out_val}, 32'd42);
    run(1);
    check_val("add_valid_pulse", {31'd0, out_valid}, 32'd0);
    run(1);
    check_val("halt_13", {31'd0, halted}, 32'd0);
    run(1);
    check_val("halt_14", {31'd0, halted}, 32'd1);
    run(5);
    check_val("halt_hold",   {31'd0, halted}, 32'd1);
    check_val("add_npulse",  n_valid, 32'd1);
    check_val("add_nwr",     n_wr, 32'd0);
    check_val("add_out_hold",{24'd0, out_val}, 32'd42);
    check_val("add_flags",   {30'd0, flags}, 32'd0);

    // ADD with carry: 200 + 100 = 44, C=1 Z=0
    clear_mem();
    mem[0] = 8'h1E; mem[1] = 8'h2F; mem[2] = 8'hE0; mem[3] = 8'hF0;
    mem[14] = 8'd200; mem[15] = 8'd100;
    do_reset();
    run(11);
    check_val("carry_out",   {24'd0, out_val}, 32'd44);
    check_val("carry_flags", {30'd0, flags}, CJ ? 32'd2 : 32'd0);

    // LDI 5; SUB 12; JZ 9
    clear_mem();
    mem[0] = 8'h55; mem[1] = 8'h3C; mem[2] = 8'h89;
    mem[3] = 8'h53; mem[4] = 8'hE0; mem[5] = 8'hF0;
    mem[9] = 8'h59; mem[10] = 8'hE0; mem[11] = 8'hF0;
    mem[12] = 8'd5;
    do_reset();
    run(7);
    check_val("sub_flags", {30'd0, flags}, CJ ? 32'd3 : 32'd0);
    run(3);
    check_val("jz_fetch", {28'd0, mem_addr}, CJ ? 32'd9 : 32'd3);
    run(9);
    check_val("jz_out",    {24'd0, out_val}, CJ ? 32'd9 : 32'd3);
    check_val("jz_halted", {31'd0, halted}, 32'd1);

    // LDI 7; STA 13; HLT
    clear_mem();
    mem[0] = 8'h57; mem[1] = 8'h4D; mem[2] = 8'hF0;
    do_reset();
    run(5);
    check_val("sta_wr",    {31'd0, mem_wr}, 32'd1);
    check_val("sta_addr",  {28'd0, mem_addr}, 32'd13);
    check_val("sta_wdata", {24'd0, mem_wdata}, 32'd7);
    en = 1'b0;
    #1;
    check_val("sta_wr_gated", {31'd0, mem_wr}, 32'd0);
    en = 1'b1;
    #1;
    check_val("sta_wr_resume", {31'd0, mem_wr}, 32'd1);
    run(1);
    check_val("sta_wr_end", {31'd0, mem_wr}, 32'd0);
    run(3);
    check_val("sta_nwr", n_wr, 32'd1);

    // JMP 15; NOP at 15 -> PC wraps to 0
    clear_mem();
    mem[0] = 8'h6F; mem[15] = 8'h00;
    do_reset();
    run(3);
    check_val("jmp_fetch", {28'd0, mem_addr}, 32'd15);
    run(3);
    check_val("wrap_fetch", {28'd0, mem_addr}, 32'd0);

    // Reset during MEM of ADD
    clear_mem();
    mem[0] = 8'h55; mem[1] = 8'h2E; mem[2] = 8'hE0; mem[3] = 8'hF0;
    mem[14] = 8'd3;
    do_reset();
    run(6);
    rst = 1'b1;
    #1;
    check_val("rstmid_wr",   {31'd0, mem_wr}, 32'd0);
    check_val("rstmid_addr", {28'd0, mem_addr}, 32'd0);
    mem[0] = 8'hE0; mem[1] = 8'hF0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    n_valid = 0;
    n_wr = 0;
    #1;
    check_val("rstmid_fetch", {28'd0, mem_addr}, 32'd0);
    run(3);
    check_val("rstmid_valid", {31'd0, out_valid}, 32'd1);
    check_val("rstmid_acc",   {24'd0, out_val}, 32'd0);
    check_val("rstmid_nwr",   n_wr, 32'd0);

    // Stall 3 cycles during LDA
    clear_mem();
    mem[0] = 8'h1E; mem[1] = 8'hE0; mem[2] = 8'hF0;
    mem[14] = 8'h5A;
    do_reset();
    run(2);
    en = 1'b0;
    check_val("stall_addr0", {28'd0, mem_addr}, 32'd14);
    run(3);
    check_val("stall_addr1", {28'd0, mem_addr}, 32'd14);
    en = 1'b1;
    run(4);
    check_val("stall_novalid", n_valid, 32'd0);
    run(1);
    check_val("stall_valid", {31'd0, out_valid}, 32'd1);
    check_val("stall_out",   {24'd0, out_val}, 32'h5A);
    en = 1'b0;
    #1;
    check_val("valid_gated", {31'd0, out_valid}, 32'd0);
    en = 1'b1;
    #1;
    check_val("valid_resume", {31'd0, out_valid}, 32'd1);
    run(1);
    check_val("valid_end", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_core_p.md
CPU_CORE_P -- requirements
Module: cpu_core_p

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning the data, accumulator and instruction word width; legal range is 8..32.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning the memory address and program counter (PC) width; ADDR_W <= DATA_W-4 is required.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, as listed below.
REQ-004 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-005 i_rst  in  1  asynchronous, active-high reset.
REQ-006 i_en  in  1  run enable; when low, all state is frozen.
REQ-007 o_mem_addr  out  ADDR_W  memory address.
REQ-008 i_mem_rdata  in  DATA_W  synchronous-read data, valid the cycle after the address is driven.
REQ-009 o_mem_wr  out  1  memory write strobe.
REQ-010 o_mem_wdata  out  DATA_W  write data.
REQ-011 o_out  out  DATA_W  output register.
REQ-012 o_out_valid  out  1  one-cycle pulse when o_out is updated.
REQ-013 o_flags  out  2  {C,Z}.
REQ-014 o_halted  out  1  core is halted.

Function
REQ-015 Instruction word format SHALL be: opcode = top 4 bits; address operand = low ADDR_W bits; immediate = low DATA_W-4 bits, zero-extended.
REQ-016 Opcodes SHALL be: NOP 0, LDA 1, ADD 2, SUB 3, STA 4, LDI 5, JMP 6, JC 7, JZ 8, OUT 14, HLT 15; all other opcodes SHALL execute as NOP.
REQ-017 State machine SHALL have the states F0, F1, EX, MEM, HALT; reset enters F0.
REQ-018 F0: o_mem_addr = PC; next state F1.
REQ-019 F1: IR <= i_mem_rdata and PC <= PC+1 (modulo 2^ADDR_W, so all-ones wraps to 0); next state EX.
REQ-020 EX for LDA/ADD/SUB: o_mem_addr = operand; next state MEM. In MEM: LDA sets A <= rdata; ADD/SUB set A <= A ± rdata; next state F0.
REQ-021 EX for STA: o_mem_wr = 1, o_mem_addr = operand, o_mem_wdata = A for exactly one cycle.
REQ-022 EX for LDI: A <= immediate.
REQ-023 EX for JMP: PC <= operand.
REQ-024 EX for OUT: o_out <= A; o_out_valid is high the following cycle only.
REQ-025 EX for HLT: next state HALT.
REQ-026 EX for NOP, and for all other EX cases not listed above: next state F0.
REQ-027 Instruction latency SHALL be 4 cycles for LDA/ADD/SUB and 3 cycles for all others.
REQ-028 ADD/SUB SHALL use DATA_W-bit modular arithmetic; SUB SHALL be computed as A + ~B + 1.
REQ-029 C SHALL be the carry-out of the add (for SUB, C=1 means no borrow, i.e. A>=B); Z SHALL be set when the result is 0; flags SHALL change only on ADD/SUB.
REQ-030 HALT SHALL hold all state, with o_halted=1 and o_mem_wr=0, until reset.
REQ-031 When i_en is low, no register SHALL change, o_mem_wr SHALL be forced to 0, and o_out_valid SHALL be forced to 0; the stalled instruction SHALL resume unchanged when i_en returns high.
REQ-032 o_mem_wr and o_out_valid SHALL be combinational decodes of state, gated by i_en.

Reset
REQ-033 While i_rst is high: state=F0, PC=0, A=0, IR=0, flags=0, o_out=0, o_out_valid=0, o_mem_wr=0, o_halted=0.
REQ-034 Reset asserted in any state, including mid-instruction or HALT, SHALL abort the instruction with no memory write; the first fetch after release SHALL be from address 0.

Configuration
REQ-035 Macro CPU_CORE_P_CJMP_EN defined: JC jumps to operand if C=1, and JZ jumps to operand if Z=1; both take 3 cycles.
REQ-036 Macro CPU_CORE_P_CJMP_EN undefined: no flag registers are built, o_flags is tied 0, and JC/JZ execute as NOP.

Structure
REQ-037 Package cpu_core_pkg SHALL hold the opcode constants, the state encodings and the flag bit indices.
REQ-038 Sub-module alu_cz (combinational, parametrised by DATA_W) SHALL produce sum, C and Z from A, B and a subtract control.

Verification (DATA_W=8, ADDR_W=4)
REQ-039 Program LDA 14; ADD 15; OUT; HLT with mem[14]=28 and mem[15]=14 -> o_out=42 with one o_out_valid pulse, o_halted=1 after 14 cycles.
REQ-040 With CJMP_EN: LDI 5; SUB 12 (mem[12]=5); JZ 9 -> flags C=1, Z=1; next fetch address is 9. Without CJMP_EN, the next fetch address is 3.
REQ-041 ADD with A=200 and mem=100 -> A=44, C=1, Z=0.
REQ-042 LDI 7; STA 13 -> o_mem_wr high for exactly one cycle with addr=13, wdata=7.
REQ-043 A NOP at address 15 -> PC wraps and the next fetch address is 0.
REQ-044 i_rst pulsed during MEM of ADD -> A=0 and o_mem_wr=0 immediately; first fetch after release is address 0. Separately, i_en held low for 3 cycles during LDA -> the instruction completes 3 cycles late with the same A.
